// File: rtl/ram_sync_if.sv
// ram_sync_if -- request/response bundle for the synchronous RAM.
//
// Signals:
//   address    : word address for read or write (ADDR_W bits)
//   write      : write request, sampled on the rising clock edge
//   write_data : data to store (WIDTH bits)
//   read       : read request, sampled on the rising clock edge
//   clear      : request a full zero-fill of the array
//   data       : registered read data (WIDTH bits)
//   data_valid : one-cycle strobe marking a fresh read result in data
//   busy       : high while a zero-fill runs; all requests are ignored
//
// Modports:
//   master : the requester (CPU memory-access stage / testbench)
//   slave  : the RAM itself
interface ram_sync_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] address;
  logic              write;
  logic [WIDTH-1:0]  write_data;
  logic              read;
  logic              clear;
  logic [WIDTH-1:0]  data;
  logic              data_valid;
  logic              busy;

  modport master (
    output address, write, write_data, read, clear,
    input  data, data_valid, busy
  );

  modport slave (
    input  address, write, write_data, read, clear,
    output data, data_valid, busy
  );
endinterface

// File: rtl/ram_sync.sv
// ram_sync -- parametrised synchronous single-port RAM with registered read,
// automatic zero-fill after reset or on request, and defined out-of-range
// behaviour (writes dropped, reads return zero).
//
// Parameters:
//   WIDTH  : data word width in bits
//   DEPTH  : number of words (need not be a power of two)
//   ADDR_W : address width, 2**ADDR_W >= DEPTH
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; restarts the zero-fill
//   bus   : ram_sync_if slave modport (requests in, data/data_valid/busy out)
module ram_sync #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  ram_sync_if.slave  bus
);

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  // DEPTH widened by one bit so address == DEPTH compares correctly when
  // DEPTH is exactly 2**ADDR_W.
  localparam logic [ADDR_W:0]   DEPTH_EXT = DEPTH[ADDR_W:0];
  localparam int                LAST_I    = DEPTH - 1;
  localparam logic [ADDR_W-1:0] LAST      = LAST_I[ADDR_W-1:0];

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] counter;
  logic [ADDR_W-1:0] counter_next;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_wdata;
  logic              rd_en;
  logic              in_range;

  logic [WIDTH-1:0]  data_q;
  logic              data_valid_q;

  // Storage has no reset; its contents become defined only through the fill.
  logic [WIDTH-1:0]  mem [DEPTH];

  assign in_range = ({1'b0, bus.address} < DEPTH_EXT);

  // State and fill counter; reset always restarts the fill from location 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      counter <= '0;
    end else begin
      state   <= state_next;
      counter <= counter_next;
    end
  end

  // Next-state logic and memory port steering. In CLEAR the port is owned by
  // the fill sequence; in IDLE clear wins over read and write.
  always_comb begin
    state_next   = state;
    counter_next = counter;
    mem_we       = 1'b0;
    mem_addr     = bus.address;
    mem_wdata    = bus.write_data;
    rd_en        = 1'b0;
    case (state)
      CLEAR: begin
        mem_we       = 1'b1;
        mem_addr     = counter;
        mem_wdata    = '0;
        counter_next = counter + ADDR_W'(1);
        if (counter == LAST) begin
          state_next   = IDLE;
          counter_next = '0;
        end
      end
      IDLE: begin
        if (bus.clear) begin
          state_next   = CLEAR;
          counter_next = '0;
        end else begin
          mem_we = bus.write && in_range;
          rd_en  = bus.read;
        end
      end
      default: begin
        state_next   = CLEAR;
        counter_next = '0;
      end
    endcase
  end

  // Array write port; mem_we is only raised for in-range addresses.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  // Registered read port. Sampling mem here sees the pre-write contents, which
  // gives read-first behaviour on a same-address read/write collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q       <= '0;
      data_valid_q <= 1'b0;
    end else begin
      data_valid_q <= rd_en;
      if (rd_en) begin
        data_q <= in_range ? mem[bus.address] : '0;
      end
    end
  end

  assign bus.data       = data_q;
  assign bus.data_valid = data_valid_q;
  assign bus.busy       = (state == CLEAR);

endmodule

// File: tb/tb_ram_sync.sv
// tb_ram_sync -- self-checking bench for ram_sync.
//
// Two instances share one stimulus stream: dut_a (DEPTH=256) and dut_b
// (DEPTH=200, non-power-of-two). A behavioural model per instance tracks the
// remaining fill cycles, the array contents and the expected read port, and
// every cycle's outputs are compared against it, alongside directed checks
// with fixed expected constants.
module tb_ram_sync;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  ram_sync_if #(.WIDTH(8), .ADDR_W(8)) bus_a ();
  ram_sync_if #(.WIDTH(8), .ADDR_W(8)) bus_b ();

  assign bus_b.address    = bus_a.address;
  assign bus_b.write      = bus_a.write;
  assign bus_b.write_data = bus_a.write_data;
  assign bus_b.read       = bus_a.read;
  assign bus_b.clear      = bus_a.clear;

  ram_sync #(.WIDTH(8), .DEPTH(256), .ADDR_W(8)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  ram_sync #(.WIDTH(8), .DEPTH(200), .ADDR_W(8)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  int total = 0;
  int bad   = 0;

  int         depth_of [2] = '{256, 200};
  int         fill_left [2];
  logic [7:0] model_mem [2][256];
  logic [7:0] exp_data [2];
  logic       exp_valid [2];

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // A fill (from reset or clear) leaves every location zero; the array is
  // inaccessible until it finishes, so zeroing it up front is equivalent.
  task automatic modelStartFill(input int k);
    fill_left[k] = depth_of[k];
    exp_valid[k] = 1'b0;
    for (int i = 0; i < 256; i++) model_mem[k][i] = 8'h00;
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      modelStartFill(k);
      exp_data[k] = 8'h00;
    end
  endtask

  task automatic modelEdge();
    int a;
    a = int'(bus_a.address);
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        modelStartFill(k);
        exp_data[k] = 8'h00;
      end else if (fill_left[k] > 0) begin
        fill_left[k]--;
        exp_valid[k] = 1'b0;
      end else if (bus_a.clear) begin
        modelStartFill(k);
      end else begin
        if (bus_a.read) begin
          exp_valid[k] = 1'b1;
          exp_data[k]  = (a < depth_of[k]) ? model_mem[k][a] : 8'h00;
        end else begin
          exp_valid[k] = 1'b0;
        end
        if (bus_a.write && a < depth_of[k]) model_mem[k][a] = bus_a.write_data;
      end
    end
  endtask

  task automatic checkAll();
    checkOutput("a_busy",  32'(bus_a.busy),       32'(fill_left[0] > 0));
    checkOutput("a_valid", 32'(bus_a.data_valid), 32'(exp_valid[0]));
    checkOutput("a_data",  32'(bus_a.data),       32'(exp_data[0]));
    checkOutput("b_busy",  32'(bus_b.busy),       32'(fill_left[1] > 0));
    checkOutput("b_valid", 32'(bus_b.data_valid), 32'(exp_valid[1]));
    checkOutput("b_data",  32'(bus_b.data),       32'(exp_data[1]));
  endtask

  task automatic setIdle();
    bus_a.write      = 1'b0;
    bus_a.read       = 1'b0;
    bus_a.clear      = 1'b0;
    bus_a.address    = 8'h00;
    bus_a.write_data = 8'h00;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    modelEdge();
    checkAll();
  endtask

  task automatic applyStimulus(input logic w, input logic [7:0] addr, input logic [7:0] wd,
                               input logic r, input logic c);
    bus_a.write      = w;
    bus_a.address    = addr;
    bus_a.write_data = wd;
    bus_a.read       = r;
    bus_a.clear      = c;
    step();
    setIdle();
  endtask

  // Steps until both instances leave the fill, counting edges for each.
  // With junk set, random reads/writes are issued to show they are ignored.
  task automatic waitFill(input int exp_a, input int exp_b, input bit junk);
    int cnt_a;
    int cnt_b;
    cnt_a = 0;
    cnt_b = 0;
    for (int n = 1; n <= 400; n++) begin
      if (junk) begin
        bus_a.write      = 1'($urandom_range(0, 1));
        bus_a.read       = 1'($urandom_range(0, 1));
        bus_a.address    = 8'($urandom_range(0, 255));
        bus_a.write_data = 8'($urandom_range(1, 255));
      end
      step();
      if (cnt_a == 0 && !bus_a.busy) cnt_a = n;
      if (cnt_b == 0 && !bus_b.busy) cnt_b = n;
      if (cnt_a != 0 && cnt_b != 0) break;
    end
    setIdle();
    checkOutput("fill_cycles_a", 32'(cnt_a), 32'(exp_a));
    checkOutput("fill_cycles_b", 32'(cnt_b), 32'(exp_b));
  endtask

  // Asserts reset between edges, checks the outputs respond at once, holds
  // it for three edges and releases.
  task automatic asyncReset();
    rst_n = 1'b0;
    #1;
    modelReset();
    checkAll();
    checkOutput("async_data_a",  32'(bus_a.data),       32'h0);
    checkOutput("async_valid_a", 32'(bus_a.data_valid), 32'h0);
    checkOutput("async_busy_a",  32'(bus_a.busy),       32'h1);
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  initial begin
    setIdle();
    rst_n = 1'b0;
    #2;
    modelReset();
    checkAll();
    repeat (3) step();
    rst_n = 1'b1;
    waitFill(256, 200, 1'b0);

    for (int i = 0; i < 256; i++) applyStimulus(1'b0, 8'(i), 8'h00, 1'b1, 1'b0);

    applyStimulus(1'b1, 8'ha0, 8'hbe, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'ha1, 8'hef, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'ha1, 8'h00, 1'b1, 1'b0);
    checkOutput("rd_a1", 32'(bus_a.data), 32'hef);
    applyStimulus(1'b0, 8'ha0, 8'h00, 1'b1, 1'b0);
    checkOutput("rd_a0", 32'(bus_a.data), 32'hbe);
    checkOutput("rd_a0_b", 32'(bus_b.data), 32'hbe);

    applyStimulus(1'b1, 8'h10, 8'h11, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h10, 8'h22, 1'b1, 1'b0);
    checkOutput("collide_old", 32'(bus_a.data), 32'h11);
    applyStimulus(1'b0, 8'h10, 8'h00, 1'b1, 1'b0);
    checkOutput("collide_new", 32'(bus_a.data), 32'h22);

    applyStimulus(1'b1, 8'hc8, 8'hff, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hc7, 8'h77, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'hc8, 8'h00, 1'b1, 1'b0);
    checkOutput("oor_b_data",  32'(bus_b.data),       32'h00);
    checkOutput("oor_b_valid", 32'(bus_b.data_valid), 32'h1);
    checkOutput("c8_a_data",   32'(bus_a.data),       32'hff);
    applyStimulus(1'b0, 8'hc7, 8'h00, 1'b1, 1'b0);
    checkOutput("c7_b_data", 32'(bus_b.data), 32'h77);

    applyStimulus(1'b1, 8'h03, 8'h5a, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h03, 8'h5a, 1'b0, 1'b0);
    waitFill(255, 199, 1'b1);
    applyStimulus(1'b0, 8'h03, 8'h00, 1'b1, 1'b0);
    checkOutput("clr_a3", 32'(bus_a.data), 32'h00);

    asyncReset();
    repeat (100) step();
    asyncReset();
    waitFill(256, 200, 1'b0);

    for (int n = 0; n < 1500; n++) begin
      logic [7:0] addr;
      addr = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 255))
                                          : 8'($urandom_range(195, 205));
      applyStimulus(1'($urandom_range(0, 2) == 0), addr, 8'($urandom),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 199) == 0));
    end

    for (int n = 0; n < 300 && (bus_a.busy || bus_b.busy); n++) step();
    applyStimulus(1'b1, 8'h05, 8'h3c, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h05, 8'h00, 1'b1, 1'b0);
    checkOutput("pre_reset_a5", 32'(bus_a.data), 32'h3c);
    asyncReset();
    waitFill(256, 200, 1'b0);
    for (int i = 0; i < 256; i++) applyStimulus(1'b0, 8'(i), 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h05, 8'h00, 1'b1, 1'b0);
    checkOutput("post_reset_a5", 32'(bus_a.data), 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
